// File: rtl/bram_stream_reader.sv
// Streams bytes from a circular BRAM buffer onto a valid/ready interface; 2-cycle wr_ptr-to-valid latency.
// A 2-entry skid FIFO absorbs the BRAM read latency, and fetches stop while out_ready is low and the FIFO is full.

module stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              not_empty,
  output logic [PTR_W:0]    count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_idx;
  logic [PTR_W-1:0]  wr_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= wr_idx + PTR_W'(1);
      end
      if (pop) rd_idx <= rd_idx + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_idx];
  assign not_empty = (count != '0);
endmodule

module bram_stream_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic              flush,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] fill_count
);
  logic [ADDR_W-1:0] iss_ptr;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              inflight;
  logic [1:0]        occ;
  logic [2:0]        demand;
  logic              pop;
  logic              issue;
  logic              fifo_push;

  assign pop    = out_valid && out_ready;
  // Slots that will be committed after this edge; a new fetch needs one free.
  assign demand = 3'(occ) + 3'(inflight) - 3'(pop);
  assign issue  = (iss_ptr != wr_ptr) && (demand < 3'd2);
  // bram_dout is only meaningful the cycle after a fetch; anything else is stale.
  assign fifo_push = inflight && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_ptr  <= '0;
      rd_ptr_q <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      iss_ptr  <= wr_ptr;
      rd_ptr_q <= wr_ptr;
      inflight <= 1'b0;
    end else begin
      if (issue) iss_ptr <= iss_ptr + ADDR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      inflight <= issue;
    end
  end

  stream_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (2)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (fifo_push),
    .push_data(bram_dout),
    .pop      (pop),
    .head     (out_data),
    .not_empty(out_valid),
    .count    (occ)
  );

  assign bram_addr  = iss_ptr;
  assign rd_ptr     = rd_ptr_q;
  assign fill_count = wr_ptr - rd_ptr_q;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised scoreboard bench for bram_stream_reader with a behavioural BRAM and producer.
module tb_bram_stream_reader;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [AW-1:0] wr_ptr;
  logic          flush;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] fill_count;

  bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_ptr    (wr_ptr),
    .flush     (flush),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_ptr    (rd_ptr),
    .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) bram_dout <= ram[bram_addr];

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] model_rd = '0;
  logic [AW-1:0] wp = '0;
  bit            mon_en = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] a_bytes [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, decides what the next rising edge does.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [AW-1:0] exp_fill;
      logic [DW-1:0] exp_byte;
      exp_fill = wr_ptr - model_rd;
      check("rd_ptr", 32'(rd_ptr), 32'(model_rd));
      check("fill_count", 32'(fill_count), 32'(exp_fill));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (reset) begin
        exp_q.delete();
        model_rd   = '0;
        prev_stall = 1'b0;
      end else if (flush) begin
        exp_q.delete();
        model_rd   = wr_ptr;
        prev_stall = 1'b0;
      end else begin
        check("no_spurious", 32'(out_valid && exp_q.size() == 0), 32'd0);
        if (out_valid && out_ready && exp_q.size() > 0) begin
          exp_byte = exp_q.pop_front();
          check("data", 32'(out_data), 32'(exp_byte));
          model_rd = model_rd + AW'(1);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    ram[wp] = d;
    exp_q.push_back(d);
    wp = wp + AW'(1);
  endtask

  task automatic publish();
    wr_ptr = wp;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    flush  = 1'b0;
    wr_ptr = '0;
    wp     = '0;
    step(1);
    reset  = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    check(name, 32'(exp_q.size()), 32'd0);
    step(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) a_bytes[i] = DW'(8'hA0 + i);
    reset = 1'b1; flush = 1'b0; wr_ptr = '0; out_ready = 1'b0;

    // Reset state holds while idle
    step(1);
    mon_en = 1'b1;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_valid", 32'(out_valid), 32'd0);
      check("t1_addr", 32'(bram_addr), 32'd0);
      check("t1_fill", 32'(fill_count), 32'd0);
    end

    // Latency and back-to-back throughput
    step(1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) put(a_bytes[i]);
    publish();
    @(negedge clk); check("t2_lat0", 32'(out_valid), 32'd0);
    @(negedge clk); check("t2_lat1", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("t2_stream", 32'(out_valid), 32'd1);
    end
    @(negedge clk); check("t2_done", 32'(out_valid), 32'd0);
    check("t2_rd", 32'(rd_ptr), 32'd4);
    check("t2_fill", 32'(fill_count), 32'd0);

    // Stall: FIFO holds two fetches and the head stays put
    step(1);
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(a_bytes[i]);
    publish();
    step(5);
    @(negedge clk);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_head", 32'(out_data), 32'(a_bytes[0]));
    check("t3_fetched", 32'(bram_addr), 32'd2);
    step(1);
    drain("t3_drain");
    check("t3_rd", 32'(rd_ptr), 32'd4);

    // Wrap-around from 2046
    out_ready = 1'b1;
    wr_ptr = AW'(2046); wp = AW'(2046); flush = 1'b1;
    step(1);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) put(DW'(8'hB0 + i));
    publish();
    @(negedge clk); check("t4_addr0", 32'(bram_addr), 32'd2046);
    @(negedge clk); check("t4_addr1", 32'(bram_addr), 32'd2047);
    @(negedge clk); check("t4_addr2", 32'(bram_addr), 32'd0);
    step(1);
    drain("t4_drain");
    check("t4_rd", 32'(rd_ptr), 32'd2);
    check("t4_addr_end", 32'(bram_addr), 32'd2);

    // Flush mid-stream with toggling ready
    for (int i = 0; i < 6; i++) put(DW'($urandom));
    publish();
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step(1);
    end
    flush = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    step(1);
    flush = 1'b0;
    @(negedge clk);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_rd", 32'(rd_ptr), 32'(wr_ptr));
    check("t5_fill", 32'(fill_count), 32'd0);
    step(1);
    for (int i = 0; i < 5; i++) put(DW'($urandom));
    publish();
    drain("t5_drain");

    // Random bursts against random backpressure
    for (int b = 0; b < 40; b++) begin
      int n;
      n = $urandom_range(0, 24);
      if (exp_q.size() + n <= 2**AW - 1) begin
        for (int i = 0; i < n; i++) put(DW'($urandom));
        publish();
      end
      for (int c = 0; c < int'($urandom_range(1, 16)); c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step(1);
      end
    end
    drain("rand_drain");

    // Reset mid-stream with a byte in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(DW'($urandom));
    publish();
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (out_valid) break;
    end
    check("t6_valid_seen", 32'(out_valid), 32'd1);
    reset = 1'b1; wr_ptr = '0; wp = '0;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_addr", 32'(bram_addr), 32'd0);
    check("t6_rd", 32'(rd_ptr), 32'd0);
    check("t6_fill", 32'(fill_count), 32'd0);
    check("t6_data", 32'(out_data), 32'd0);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
